// File: rtl/td_detect_pkg.sv
// rtl/td_detect_pkg.sv - shared types and default windows for the TV standard detector
package td_detect_pkg;

  typedef enum logic [1:0] {STD_NONE, STD_NTSC, STD_PAL} td_std_e;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, HOLD} td_state_e;

  localparam int DEF_CNT_W         = 8;
  localparam int DEF_NTSC_MIN      = 4;
  localparam int DEF_NTSC_MAX      = 14;
  localparam int DEF_PAL_MIN       = 20;
  localparam int DEF_PAL_MAX       = 31;
  localparam int DEF_LOCK_FRAMES   = 3;
  localparam int DEF_UNLOCK_FRAMES = 2;
  localparam int DEF_TO_CLKS       = 1 << 20;

endpackage

// File: rtl/td_sync_edge.sv
// rtl/td_sync_edge.sv - two-flop synchroniser with registered rising-edge pulse
module td_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1, s2;

  // rise lands three clocks after the pin edge; level trails s2 by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
    end
  end

endmodule

// File: rtl/td_std_detect.sv
// rtl/td_std_detect.sv - NTSC/PAL detector: VS-low line count, classification, lock hysteresis, HS timeout
module td_std_detect
  import td_detect_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int NTSC_MIN      = DEF_NTSC_MIN,
  parameter int NTSC_MAX      = DEF_NTSC_MAX,
  parameter int PAL_MIN       = DEF_PAL_MIN,
  parameter int PAL_MAX       = DEF_PAL_MAX,
  parameter int LOCK_FRAMES   = DEF_LOCK_FRAMES,
  parameter int UNLOCK_FRAMES = DEF_UNLOCK_FRAMES,
  parameter int TO_CLKS       = DEF_TO_CLKS
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iTD_HS,
  input  logic             iTD_VS,
  output logic             oTD_Stable,
  output logic             oNTSC,
  output logic             oPAL,
  output logic [CNT_W-1:0] oVS_LINES,
  output logic             oSTD_CHG
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] N_LO     = CNT_W'(NTSC_MIN);
  localparam logic [CNT_W-1:0] N_HI     = CNT_W'(NTSC_MAX);
  localparam logic [CNT_W-1:0] P_LO     = CNT_W'(PAL_MIN);
  localparam logic [CNT_W-1:0] P_HI     = CNT_W'(PAL_MAX);
  localparam logic [7:0]       LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic [7:0]       UNLOCK_N = 8'(UNLOCK_FRAMES);
  localparam int               TO_W     = $clog2(TO_CLKS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CLKS - 1);

  logic             hs_r, vs_r, vs_lvl, hs_lvl_unused;
  logic [CNT_W-1:0] line_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       match, miss;
  logic [2:0]       prev_triple;
  logic             timeout, locked_c;
  td_std_e          cls, cand, std;
  td_state_e        state;

  td_sync_edge u_hs (.clk(iCLK), .rst_n(iRST_N), .din(iTD_HS), .level(hs_lvl_unused), .rise(hs_r));
  td_sync_edge u_vs (.clk(iCLK), .rst_n(iRST_N), .din(iTD_VS), .level(vs_lvl),        .rise(vs_r));

  always_comb begin
    cls = STD_NONE;
    if (line_cnt >= N_LO && line_cnt <= N_HI)      cls = STD_NTSC;
    else if (line_cnt >= P_LO && line_cnt <= P_HI) cls = STD_PAL;
  end

  // an HS edge in the same cycle ends the timeout so that line is still counted
  assign timeout  = (to_cnt == TO_LAST) && !hs_r;
  assign locked_c = (state == LOCKED) || (state == HOLD);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)              to_cnt <= '0;
    else if (hs_r)            to_cnt <= '0;
    else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= UNLOCKED;
      cand        <= STD_NONE;
      std         <= STD_NONE;
      match       <= '0;
      miss        <= '0;
      line_cnt    <= '0;
      oVS_LINES   <= '0;
      oTD_Stable  <= 1'b0;
      oNTSC       <= 1'b0;
      oPAL        <= 1'b0;
      oSTD_CHG    <= 1'b0;
      prev_triple <= '0;
    end else begin
      if (timeout) begin
        state    <= UNLOCKED;
        match    <= '0;
        miss     <= '0;
        line_cnt <= '0;
      end else if (vs_r) begin
        line_cnt  <= '0;
        oVS_LINES <= line_cnt;
        case (state)
          UNLOCKED: if (cls != STD_NONE) begin
            cand  <= cls;
            match <= 8'd1;
            if (LOCK_N == 8'd1) begin
              state <= LOCKED;
              std   <= cls;
            end else begin
              state <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (cls == STD_NONE) begin
              state <= UNLOCKED;
            end else if (cls == cand) begin
              match <= match + 8'd1;
              if (match + 8'd1 >= LOCK_N) begin
                state <= LOCKED;
                std   <= cand;
              end
            end else begin
              cand  <= cls;
              match <= 8'd1;
            end
          end
          LOCKED: if (cls != std) begin
            miss  <= 8'd1;
            state <= (UNLOCK_N == 8'd1) ? UNLOCKED : HOLD;
          end
          default: begin
            if (cls == std) begin
              state <= LOCKED;
              miss  <= '0;
            end else begin
              miss <= miss + 8'd1;
              if (miss + 8'd1 >= UNLOCK_N) state <= UNLOCKED;
            end
          end
        endcase
      end else if (hs_r && !vs_lvl && line_cnt != CNT_MAX) begin
        line_cnt <= line_cnt + 1'b1;
      end

      oTD_Stable  <= locked_c;
      oNTSC       <= locked_c && (std == STD_NTSC);
      oPAL        <= locked_c && (std == STD_PAL);
      prev_triple <= {oTD_Stable, oNTSC, oPAL};
      oSTD_CHG    <= {oTD_Stable, oNTSC, oPAL} != prev_triple;
    end
  end

endmodule

// File: tb/tb_td_std_detect.sv
// tb/tb_td_std_detect.sv - directed bench for td_std_detect
module tb_td_std_detect;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b0;
  logic       vs = 1'b0;
  logic       stable, ntsc, pal, chg;
  logic [7:0] lines;
  int         n_tests = 0;
  int         n_fail = 0;
  int         chg_cnt = 0;

  td_std_detect #(.TO_CLKS(TO)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iTD_HS(hs), .iTD_VS(vs),
    .oTD_Stable(stable), .oNTSC(ntsc), .oPAL(pal),
    .oVS_LINES(lines), .oSTD_CHG(chg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (chg) chg_cnt <= chg_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hs_pulse();
    hs = 1'b1; tick(4);
    hs = 1'b0; tick(4);
  endtask

  // VS-low window of n lines, then VS high with two trailing lines
  task automatic field(input int n);
    vs = 1'b0; tick(6);
    repeat (n) hs_pulse();
    vs = 1'b1; tick(6);
    repeat (2) hs_pulse();
  endtask

  function automatic logic [31:0] triple();
    return {29'd0, stable, ntsc, pal};
  endfunction

  initial begin
    tick(3);
    check("reset_triple", triple(), 0);
    check("reset_lines", 32'(lines), 0);
    check("reset_chg", 32'(chg), 0);
    rst_n = 1'b1;
    tick(3);

    // NTSC acquisition
    field(9); field(9);
    check("ntsc_2fields", triple(), 0);
    field(9);
    check("ntsc_lock", triple(), 3'b110);
    check("ntsc_lines", 32'(lines), 9);
    check("ntsc_chg", 32'(chg_cnt), 1);

    // Hysteresis
    field(17);
    check("hold_triple", triple(), 3'b110);
    check("hold_lines", 32'(lines), 17);
    field(9);
    check("relock", triple(), 3'b110);
    field(17); field(17);
    check("unlock_2miss", triple(), 0);
    check("unlock_chg", 32'(chg_cnt), 2);

    // NTSC -> PAL switch
    field(9); field(9); field(9);
    check("sw_ntsc", triple(), 3'b110);
    field(25);
    check("sw_pal1", triple(), 3'b110);
    field(25);
    check("sw_pal2", triple(), 0);
    field(25); field(25);
    check("sw_pal4", triple(), 0);
    field(25);
    check("sw_pal_lock", triple(), 3'b101);
    check("sw_chg", 32'(chg_cnt), 5);

    // Window boundaries
    field(19); field(32);
    check("bnd_lines32", 32'(lines), 32);
    check("bnd_unlock", triple(), 0);
    field(19); field(32); field(19);
    check("bnd_nolock", triple(), 0);
    field(20); field(31); field(20);
    check("bnd_pal_lock", triple(), 3'b101);
    check("bnd_lines20", 32'(lines), 20);

    // HS loss timeout
    tick(30);
    check("to_before", triple(), 3'b101);
    tick(44);
    check("to_after", triple(), 0);
    field(9); field(9);
    check("to_2fields", triple(), 0);
    field(9);
    check("to_relock", triple(), 3'b110);

    // Line counter saturation
    field(300);
    check("sat_lines", 32'(lines), 255);
    check("sat_hold", triple(), 3'b110);
    field(9);

    // Reset mid-field
    vs = 1'b0; tick(6);
    repeat (5) hs_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_triple", triple(), 0);
    check("rst_lines", 32'(lines), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    repeat (9) hs_pulse();
    vs = 1'b1; tick(6);
    repeat (2) hs_pulse();
    check("rst_restart_lines", 32'(lines), 9);
    check("rst_restart_triple", triple(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
